conv_frame_sequencer: RTL and testbench
=======================================

# conv_frame_sequencer

Frame-level controller for the `convolution` line-buffer engine. Pulls one frame of raster-order pixels from an upstream valid/ready source, advances the engine only when a pixel is available and the downstream sink can accept, drains the engine's row-fill latency with zero pixels at end of frame, and re-emits aligned outputs with frame/row markers. Sits between the frame-buffer reader and the output writer, replacing free-running, hand-timed pixel feeding.

## Interface
- `WORD_SIZE`, 8, pixel width in bits
- `ROW_SIZE`, 540, pixels per row (image width)
- `IMAGE_HEIGHT`, 360, rows per frame
- `LATENCY`, ROW_SIZE+1, engine advances between a pixel entering and its output appearing; legal range 1..ROW_SIZE*IMAGE_HEIGHT
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a frame from IDLE, ignored otherwise
- `in_valid`  in  1  upstream pixel valid
- `in_pixel`  in  WORD_SIZE  upstream pixel, raster order
- `in_ready`  out  1  pixel consumed this cycle
- `conv_en`  out  1  engine advance enable (engine shifts only when high)
- `conv_pixel`  out  WORD_SIZE  pixel presented to engine `inputPixel`
- `conv_out`  in  WORD_SIZE  engine `outputPixel`
- `out_valid`  out  1  output pixel valid
- `out_pixel`  out  WORD_SIZE  output pixel
- `out_eol`  out  1  out_pixel is last of its row
- `out_last`  out  1  out_pixel is last of frame
- `out_ready`  in  1  downstream accepts
- `busy`  out  1  high in any state but IDLE
- `frame_done`  out  1  one-cycle pulse after the last output handshake

## Operation
- States: IDLE, FILL, STREAM, FLUSH, DONE. N = ROW_SIZE*IMAGE_HEIGHT.
- Advance counter `adv` (0..N+LATENCY-1) cleared on start. Output slot free: `free = !out_valid || out_ready`.
- IDLE: `start` -> FILL, adv=0, counters cleared.
- FILL (adv < LATENCY): `conv_en = in_valid`; no output captured. Leaving: when advance makes adv==LATENCY -> STREAM (or FLUSH if all N inputs consumed, i.e. LATENCY==N).
- STREAM: `conv_en = in_valid && free`; each advance also captures `conv_out` into out_pixel as output index adv-LATENCY. After input N-1 consumed -> FLUSH.
- FLUSH: `conv_en = free`, `conv_pixel = 0`, `in_ready = 0`; each advance captures an output. After advance N+LATENCY-1 -> DONE once the last output's handshake completes.
- DONE: `frame_done = 1` for one cycle -> IDLE.
- `in_ready = conv_en` in FILL/STREAM, 0 elsewhere; `conv_pixel = in_pixel` in FILL/STREAM.
- Output counters row/col track captured index; `out_eol` when col==ROW_SIZE-1, `out_last` when index==N-1. Exactly N outputs per frame.
- out_valid/out_pixel/flags held stable while `out_valid && !out_ready`.
- Counters sized $clog2 of their maximum+1; no wrap within a frame; cleared on start.

## Timing
- Reset (rst low, async): state IDLE; `in_ready`, `conv_en`, `out_valid`, `out_eol`, `out_last`, `busy`, `frame_done` = 0; `out_pixel`, `conv_pixel` = 0.
- `in_ready`, `conv_en`, `conv_pixel` combinational from state/in_valid/out_ready; `out_*` registered, valid the cycle after the capturing advance.
- `conv_out` sampled at the same edge as the advance that counts toward the output index.
- Full throughput: one pixel per cycle with in_valid and out_ready held high; frame takes N+LATENCY advance cycles plus 2 (last handshake, DONE).
- `start` during busy ignored. `in_valid` outside FILL/STREAM ignored. Reset mid-frame aborts immediately; next frame needs new `start`.

## Configuration
- `CONV_SEQ_BORDER_ZERO_EN` defined: outputs with row 0, row IMAGE_HEIGHT-1, col 0 or col ROW_SIZE-1 are forced to 0 (flags and timing unchanged).
- Undefined: `conv_out` passed through for every position.

## Test plan
- Bench params ROW_SIZE=4, IMAGE_HEIGHT=3, LATENCY=5, engine model = pure 5-advance delay line.
- Reset: pulse rst low mid-STREAM -> all outputs 0, busy=0 same cycle; start afterwards produces a full 12-pixel frame.
- Streaming: in_valid/out_ready high, inputs 0x01..0x0C -> outputs 0x01..0x0C on 12 consecutive cycles, out_eol on 0x04/0x08/0x0C, out_last on 0x0C, frame_done one cycle after, 17 advances total.
- Backpressure: out_ready low 3 cycles at output 0x06 -> out_pixel holds 0x06, conv_en=0, in_ready=0 during stall; no loss or duplication.
- Starvation: in_valid low 4 cycles during FILL and STREAM -> conv_en stays 0, output stream unchanged; FLUSH proceeds with in_valid low.
- Start-while-busy and macro: start pulse mid-frame ignored; with CONV_SEQ_BORDER_ZERO_EN, outputs are 0 except 0x06 and 0x07.

Source files
------------

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for the convolution line-buffer engine: handshaked feed, latency drain, framed output.
// Optional: define CONV_SEQ_BORDER_ZERO_EN to force border outputs (first/last row, first/last column) to zero.
module conv_frame_sequencer #(
    parameter int WORD_SIZE    = 8,
    parameter int ROW_SIZE     = 540,
    parameter int IMAGE_HEIGHT = 360,
    parameter int LATENCY      = ROW_SIZE + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [WORD_SIZE-1:0] in_pixel,
    output logic                 in_ready,
    output logic                 conv_en,
    output logic [WORD_SIZE-1:0] conv_pixel,
    input  logic [WORD_SIZE-1:0] conv_out,
    output logic                 out_valid,
    output logic [WORD_SIZE-1:0] out_pixel,
    output logic                 out_eol,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int N     = ROW_SIZE * IMAGE_HEIGHT;
    localparam int TOTAL = N + LATENCY;
    localparam int ADV_W = $clog2(TOTAL + 1);
    localparam int COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [ADV_W-1:0] ADV_LAT_M1 = ADV_W'(LATENCY - 1);
    localparam logic [ADV_W-1:0] ADV_N_M1   = ADV_W'(N - 1);
    localparam logic [ADV_W-1:0] ADV_END    = ADV_W'(TOTAL);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(ROW_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMAGE_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [ADV_W-1:0]     adv_q, adv_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 out_valid_q, out_valid_d;
    logic [WORD_SIZE-1:0] out_pixel_q, out_pixel_d;
    logic                 out_eol_q, out_eol_d;
    logic                 out_last_q, out_last_d;

    logic free;
    logic capture;
    logic on_border;

    assign free    = !out_valid_q || out_ready;
    assign capture = conv_en && (state_q == S_STREAM || state_q == S_FLUSH);

`ifdef CONV_SEQ_BORDER_ZERO_EN
    assign on_border = (row_q == '0) || (row_q == ROW_LAST) || (col_q == '0) || (col_q == COL_LAST);
`else
    assign on_border = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            adv_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_eol_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            adv_q       <= adv_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_eol_q   <= out_eol_d;
            out_last_q  <= out_last_d;
        end
    end

    // adv_q equals inputs consumed while in FILL/STREAM, so it alone decides when input ends.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FILL;
            end
            S_FILL: begin
                if (conv_en && adv_q == ADV_LAT_M1)
                    state_d = (adv_q == ADV_N_M1) ? S_FLUSH : S_STREAM;
            end
            S_STREAM: begin
                if (conv_en && adv_q == ADV_N_M1) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (adv_q == ADV_END && out_valid_q && out_ready) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        conv_en    = 1'b0;
        in_ready   = 1'b0;
        conv_pixel = '0;
        unique case (state_q)
            S_FILL: begin
                conv_en    = in_valid;
                in_ready   = in_valid;
                conv_pixel = in_pixel;
            end
            S_STREAM: begin
                conv_en    = in_valid && free;
                in_ready   = in_valid && free;
                conv_pixel = in_pixel;
            end
            S_FLUSH: begin
                conv_en = free && (adv_q != ADV_END);
            end
            default: begin
                conv_en = 1'b0;
            end
        endcase
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_DONE);
    end

    // Output slot only reloads on an advance, which in STREAM/FLUSH already implies the slot is free.
    always_comb begin
        adv_d       = adv_q;
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        out_eol_d   = out_eol_q;
        out_last_d  = out_last_q;
        if (state_q == S_IDLE && start) begin
            adv_d = '0;
            col_d = '0;
            row_d = '0;
        end else begin
            if (conv_en) adv_d = adv_q + ADV_W'(1);
            if (capture) begin
                out_valid_d = 1'b1;
                out_pixel_d = on_border ? '0 : conv_out;
                out_eol_d   = (col_q == COL_LAST);
                out_last_d  = (col_q == COL_LAST) && (row_q == ROW_LAST);
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q != ROW_LAST) row_d = row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end else if (out_ready) begin
                out_valid_d = 1'b0;
                out_eol_d   = 1'b0;
                out_last_d  = 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_eol   = out_eol_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Scoreboard bench for conv_frame_sequencer on a 4x3 frame with a 5-advance delay-line engine model.
// Expected border-zero values are selected when CONV_SEQ_BORDER_ZERO_EN is defined.
module tb_conv_frame_sequencer;

    localparam int WS   = 8;
    localparam int RS   = 4;
    localparam int IH   = 3;
    localparam int LAT  = 5;
    localparam int NPIX = RS * IH;

    // Hand-computed expected output stream (index k -> value, bit k of the flag masks)
`ifdef CONV_SEQ_BORDER_ZERO_EN
    localparam logic [7:0] EXP_PIX [NPIX] = '{8'h00, 8'h00, 8'h00, 8'h00,
                                              8'h00, 8'h06, 8'h07, 8'h00,
                                              8'h00, 8'h00, 8'h00, 8'h00};
`else
    localparam logic [7:0] EXP_PIX [NPIX] = '{8'h01, 8'h02, 8'h03, 8'h04,
                                              8'h05, 8'h06, 8'h07, 8'h08,
                                              8'h09, 8'h0A, 8'h0B, 8'h0C};
`endif
    localparam logic [NPIX-1:0] EXP_EOL  = 12'b1000_1000_1000;
    localparam logic [NPIX-1:0] EXP_LAST = 12'b1000_0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          inValid = 1'b0;
    logic [WS-1:0] inPixel = '0;
    logic          inReady;
    logic          convEn;
    logic [WS-1:0] convPixel;
    logic [WS-1:0] convOut;
    logic          outValid;
    logic [WS-1:0] outPixel;
    logic          outEol;
    logic          outLast;
    logic          outReady = 1'b1;
    logic          busy;
    logic          frameDone;

    always #5 clk = ~clk;

    conv_frame_sequencer #(
        .WORD_SIZE   (WS),
        .ROW_SIZE    (RS),
        .IMAGE_HEIGHT(IH),
        .LATENCY     (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (inValid),
        .in_pixel  (inPixel),
        .in_ready  (inReady),
        .conv_en   (convEn),
        .conv_pixel(convPixel),
        .conv_out  (convOut),
        .out_valid (outValid),
        .out_pixel (outPixel),
        .out_eol   (outEol),
        .out_last  (outLast),
        .out_ready (outReady),
        .busy      (busy),
        .frame_done(frameDone)
    );

    // Engine stand-in: pure delay line that shifts only on an advance
    logic [WS-1:0] delayLine [LAT];
    always @(posedge clk) begin
        if (convEn) begin
            delayLine[0] <= convPixel;
            for (int i = 1; i < LAT; i++) delayLine[i] <= delayLine[i-1];
        end
    end
    assign convOut = delayLine[LAT-1];

    typedef struct packed {
        logic [7:0] pix;
        logic       eol;
        logic       last;
    } exp_t;

    exp_t expQ[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cycleNum = 0;
    int   advCount = 0;
    int   busyCount = 0;
    int   firstHs = -1;
    int   lastHs = -1;
    bit   prevLastHs = 0;
    bit   prevFrameDone = 0;
    bit   frameDoneSeen = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and tracks frame-level timing
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cycleNum++;
            if (rst) begin
                if (start && !busy) begin
                    advCount  = 0;
                    busyCount = 0;
                    firstHs   = -1;
                    lastHs    = -1;
                end
                if (prevFrameDone) checkOutput("frame_done pulse width", frameDone, 0);
                if (frameDone) begin
                    checkOutput("frame_done follows last handshake", prevLastHs, 1);
                    checkOutput("advances per frame", advCount, 17);
                    frameDoneSeen = 1;
                end
                if (convEn) advCount++;
                if (busy) busyCount++;
                if (outValid && outReady) begin
                    if (expQ.size() == 0) begin
                        checkOutput("spurious output queue depth", expQ.size(), 1);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("out_pixel", outPixel, e.pix);
                        checkOutput("out_eol", outEol, e.eol);
                        checkOutput("out_last", outLast, e.last);
                        if (firstHs < 0) firstHs = cycleNum;
                        lastHs = cycleNum;
                    end
                end
                prevLastHs    = outValid && outReady && outLast;
                prevFrameDone = frameDone;
            end else begin
                prevLastHs    = 0;
                prevFrameDone = 0;
            end
        end
    end

    task automatic checkResetState();
        checkOutput("reset out_valid", outValid, 0);
        checkOutput("reset out_pixel", outPixel, 0);
        checkOutput("reset out_eol", outEol, 0);
        checkOutput("reset out_last", outLast, 0);
        checkOutput("reset in_ready", inReady, 0);
        checkOutput("reset conv_en", convEn, 0);
        checkOutput("reset conv_pixel", convPixel, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset frame_done", frameDone, 0);
    endtask

    // One frame: inputs 0x01..0x0C with optional starvation, output stall, mid-frame start or reset
    task automatic applyStimulus(input string tag, input int starveA, input int starveB,
                                 input bit stallOn, input bit midStart, input int resetAt,
                                 input bit checkTiming);
        int idx = 0;
        int cyc = 0;
        int starveLeft = 0;
        int stallLeft = 0;
        bit stallUsed = 0;
        bit aUsed = 0;
        bit bUsed = 0;
        bit aborted = 0;
        $display("[TB] frame: %s", tag);
        for (int k = 0; k < NPIX; k++) expQ.push_back({EXP_PIX[k], EXP_EOL[k], EXP_LAST[k]});
        frameDoneSeen = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!frameDoneSeen && cyc < 200) begin
            if (!aUsed && idx == starveA) begin starveLeft = 4; aUsed = 1; end
            if (!bUsed && idx == starveB) begin starveLeft = 4; bUsed = 1; end
            if (stallOn && !stallUsed && outValid && outPixel == 8'h06) begin
                stallLeft = 3;
                stallUsed = 1;
            end
            inValid  = (idx < NPIX) && (starveLeft == 0);
            inPixel  = 8'(idx + 1);
            outReady = (stallLeft == 0);
            start    = midStart && (cyc == 8);
            if (cyc == resetAt) begin
                #1 rst = 1'b0;
                #1 checkResetState();
                expQ.delete();
                @(negedge clk);
                #2 rst = 1'b1;
                aborted = 1;
                break;
            end
            @(negedge clk);
            if (starveLeft > 0) begin
                checkOutput("conv_en while starved", convEn, 0);
                starveLeft--;
            end
            if (stallLeft > 0) begin
                checkOutput("stall out_pixel hold", outPixel, 8'h06);
                checkOutput("stall out_valid hold", outValid, 1);
                checkOutput("stall conv_en", convEn, 0);
                checkOutput("stall in_ready", inReady, 0);
                stallLeft--;
            end
            if (midStart && cyc == 8) checkOutput("busy at ignored start", busy, 1);
            if (inReady) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        start    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b1;
        if (!aborted) begin
            checkOutput("frame completed within budget", frameDoneSeen, 1);
            checkOutput("scoreboard drained", expQ.size(), 0);
            checkOutput("inputs consumed", idx, NPIX);
            if (checkTiming) begin
                checkOutput("busy cycles per frame", busyCount, 19);
                checkOutput("output span cycles", lastHs - firstHs, 11);
            end
        end
    endtask

    initial begin
        #2 rst = 1'b0;
        #5 checkResetState();
        #6 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus("full throughput", -1, -1, 0, 0, -1, 1);
        applyStimulus("backpressure at 0x06", -1, -1, 1, 0, -1, 0);
        applyStimulus("starvation in FILL and STREAM", 2, 8, 0, 0, -1, 0);
        applyStimulus("start while busy", -1, -1, 0, 1, -1, 0);
        applyStimulus("reset mid-STREAM", -1, -1, 0, 0, 10, 0);
        checkOutput("idle after reset busy", busy, 0);
        applyStimulus("frame after reset", -1, -1, 0, 0, -1, 1);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
